// File: rtl/tmr_vote_reg.sv
// rtl/tmr_vote_reg.sv - TMR storage register with majority vote, scrub, fault injection and error accounting
module tmr_vote_reg #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [WIDTH-1:0]       d,
  input  logic                   scrub_en,
  input  logic                   inj_en,
  input  logic [1:0]             inj_sel,
  input  logic [WIDTH-1:0]       inj_mask,
  input  logic                   clr,
  output logic [WIDTH-1:0]       q,
  output logic [2:0]             err_lane,
  output logic                   err_multi,
  output logic [2:0]             err_sticky,
  output logic [3*CNT_WIDTH-1:0] err_cnt
);

  logic [WIDTH-1:0]     r_q [3];
  logic [WIDTH-1:0]     r_d [3];
  logic [CNT_WIDTH-1:0] cnt_q [3];
  logic [CNT_WIDTH-1:0] cnt_d [3];
  logic [2:0]           lane_prev_q;
  logic [2:0]           sticky_q;
  logic [2:0]           sticky_d;
  logic [2:0]           event_w;

  assign q = (r_q[0] & r_q[1]) | (r_q[1] & r_q[2]) | (r_q[0] & r_q[2]);

  assign err_multi = (err_lane[0] & err_lane[1]) | (err_lane[1] & err_lane[2])
                   | (err_lane[0] & err_lane[2]);
  assign event_w   = err_lane & ~lane_prev_q;
  assign sticky_d  = (sticky_q & ~{3{clr}}) | err_lane;
  assign err_sticky = sticky_q;

  for (genvar k = 0; k < 3; k++) begin : g_lane
    localparam logic [1:0] SEL = 2'(k);

    assign err_lane[k] = |(r_q[k] ^ q);
    assign err_cnt[k*CNT_WIDTH +: CNT_WIDTH] = cnt_q[k];

    // load beats injection beats scrub; an injected replica skips scrub that cycle
    always_comb begin
      r_d[k] = r_q[k];
      if (load) begin
        r_d[k] = d;
      end else if (inj_en && (inj_sel == SEL)) begin
        r_d[k] = r_q[k] ^ inj_mask;
      end else if (scrub_en) begin
        r_d[k] = q;
      end
    end

    // a clear coinciding with a new event leaves exactly that event counted
    always_comb begin
      cnt_d[k] = cnt_q[k];
      if (clr) begin
        cnt_d[k] = event_w[k] ? CNT_WIDTH'(1) : '0;
      end else if (event_w[k] && !(&cnt_q[k])) begin
        cnt_d[k] = cnt_q[k] + CNT_WIDTH'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_q[k]   <= '0;
        cnt_q[k] <= '0;
      end else begin
        r_q[k]   <= r_d[k];
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane_prev_q <= '0;
      sticky_q    <= '0;
    end else begin
      lane_prev_q <= err_lane;
      sticky_q    <= sticky_d;
    end
  end

endmodule

// File: tb/tb_tmr_vote_reg.sv
// tb/tb_tmr_vote_reg.sv - directed self-checking bench for tmr_vote_reg
module tb_tmr_vote_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [7:0]  d;
  logic        scrub_en;
  logic        inj_en;
  logic [1:0]  inj_sel;
  logic [7:0]  inj_mask;
  logic        clr;
  logic [7:0]  q;
  logic [2:0]  err_lane;
  logic        err_multi;
  logic [2:0]  err_sticky;
  logic [11:0] err_cnt;

  int n_cmp = 0;
  int n_err = 0;

  tmr_vote_reg #(.WIDTH(8), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .d(d), .scrub_en(scrub_en),
    .inj_en(inj_en), .inj_sel(inj_sel), .inj_mask(inj_mask), .clr(clr),
    .q(q), .err_lane(err_lane), .err_multi(err_multi),
    .err_sticky(err_sticky), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic inject(input logic [1:0] sel, input logic [7:0] mask);
    inj_en = 1'b1; inj_sel = sel; inj_mask = mask;
    tick();
    inj_en = 1'b0; inj_mask = 8'h00;
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; d = 8'h00; scrub_en = 1'b0;
    inj_en = 1'b0; inj_sel = 2'd0; inj_mask = 8'h00; clr = 1'b0;
    tick(); tick();
    check("rst_q", q, 8'h00);
    check("rst_lane", err_lane, 3'b000);
    check("rst_multi", err_multi, 1'b0);
    check("rst_sticky", err_sticky, 3'b000);
    check("rst_cnt", err_cnt, 12'h000);

    // load A5
    rst_n = 1'b1; load = 1'b1; d = 8'hA5;
    tick();
    load = 1'b0;
    check("load_q", q, 8'hA5);
    check("load_lane", err_lane, 3'b000);
    check("load_cnt", err_cnt, 12'h000);

    // persistent fault on r1
    inject(2'd1, 8'h01);
    check("inj1_q", q, 8'hA5);
    check("inj1_lane", err_lane, 3'b010);
    tick();
    check("inj1_sticky", err_sticky, 3'b010);
    check("inj1_cnt", err_cnt, 12'h010);
    tick(); tick(); tick();
    check("inj1_hold_lane", err_lane, 3'b010);
    check("inj1_hold_cnt", err_cnt, 12'h010);

    // scrub restores r1
    scrub_en = 1'b1;
    tick();
    check("scrub_lane", err_lane, 3'b000);
    check("scrub_cnt", err_cnt, 12'h010);

    // scrubbed fault visible for one cycle only
    inject(2'd1, 8'h01);
    check("pulse_lane_hi", err_lane, 3'b010);
    tick();
    check("pulse_lane_lo", err_lane, 3'b000);
    check("pulse_cnt", err_cnt, 12'h020);
    for (int i = 0; i < 19; i++) begin
      inject(2'd1, 8'h01);
      tick();
    end
    check("sat_cnt", err_cnt, 12'h0F0);
    check("sat_q", q, 8'hA5);
    check("sat_sticky", err_sticky, 3'b010);

    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_sticky", err_sticky, 3'b000);
    check("clr_cnt", err_cnt, 12'h000);

    // faults on different bits of r0 and r2
    scrub_en = 1'b0;
    inject(2'd0, 8'h01);
    inject(2'd2, 8'h80);
    check("multi_q", q, 8'hA5);
    check("multi_lane", err_lane, 3'b101);
    check("multi_flag", err_multi, 1'b1);
    inject(2'd2, 8'h01);
    check("double_q", q, 8'hA4);
    check("double_lane", err_lane, 3'b110);

    // rebuild clean state, then three scrubbed r0 events
    load = 1'b1; d = 8'hA5;
    tick();
    load = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("reclr_cnt", err_cnt, 12'h000);
    check("reclr_sticky", err_sticky, 3'b000);
    scrub_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      inject(2'd0, 8'h01);
      tick();
    end
    check("cnt0_3", err_cnt, 12'h003);
    inject(2'd0, 8'h01);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_evt_sticky", err_sticky, 3'b001);
    check("clr_evt_cnt", err_cnt, 12'h001);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_only_sticky", err_sticky, 3'b000);
    check("clr_only_cnt", err_cnt, 12'h000);

    // load beats injection
    scrub_en = 1'b0;
    load = 1'b1; d = 8'h3C;
    inject(2'd0, 8'hFF);
    load = 1'b0;
    check("ldwin_q", q, 8'h3C);
    check("ldwin_lane", err_lane, 3'b000);

    // inj_sel == 3 is ignored
    inject(2'd3, 8'hFF);
    check("sel3_q", q, 8'h3C);
    check("sel3_lane", err_lane, 3'b000);

    inject(2'd2, 8'h0F);
    tick();
    check("pre_rst_sticky", err_sticky, 3'b100);
    check("pre_rst_cnt", err_cnt, 12'h100);
    rst_n = 1'b0;
    tick();
    check("mid_rst_q", q, 8'h00);
    check("mid_rst_lane", err_lane, 3'b000);
    check("mid_rst_sticky", err_sticky, 3'b000);
    check("mid_rst_cnt", err_cnt, 12'h000);
    rst_n = 1'b1;
    tick();
    check("post_rst_cnt", err_cnt, 12'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
